usb_pkt_router: RTL and testbench
=================================

USB_PKT_ROUTER -- requirements
Module: usb_pkt_router

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning stream word width (>=32).
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning buffer depth in words (power of 2).
REQ-003 The block SHALL have parameter NUM_CH, default 24, meaning DAC channel count (2..256).
REQ-004 The block SHALL have parameter SEG_LEN, default 32, meaning words per channel in segmented mode.
REQ-005 The block SHALL have ports: clock in 1, sole clock; rst_n in 1, synchronous active-low reset.
REQ-006 The block SHALL have ports: in_data in DATA_W, USB word; in_valid in 1; in_last in 1, last word of USB packet; in_ready out 1.
REQ-007 The block SHALL have ports: out_data out DATA_W; out_valid out 1; out_ready in 1; out_wren out NUM_CH, one-hot channel write enable.
REQ-008 The block SHALL have port: drop_pulse out 1, one-cycle flag per discarded packet or word.

Function
REQ-009 Transfer occurs when in_valid&&in_ready (input) or out_valid&&out_ready (output); no other qualification.
REQ-010 Header: word with (in_data[31:0] & 32'hFF0000FF)==32'hFF0000AA; mode=in_data[23:16], base=in_data[15:8].
REQ-011 Parser states: S_HDR (await header), S_PAY (route payload), S_DROP (discard to in_last).
REQ-012 S_HDR: header with in_last=0 and base<NUM_CH and mode in {0x00,0x01} -> latch mode/base, word index=0, go S_PAY; header itself never buffered.
REQ-013 S_HDR: non-header, bad base or bad mode -> drop_pulse=1; go S_DROP if in_last=0, else stay S_HDR.
REQ-014 S_PAY mode 0x00 (segmented): channel=base+index/SEG_LEN; mode 0x01 (single): channel=base for all words.
REQ-015 S_PAY: each accepted word pushed with its channel tag; index increments per word; in_last returns to S_HDR.
REQ-016 Segmented channel >=NUM_CH: word discarded (not pushed), drop_pulse=1 that cycle, in_ready stays high.
REQ-017 S_DROP: all words accepted and discarded; in_last returns to S_HDR.
REQ-018 in_ready=0 only when buffer full and the current word would be pushed; header/dropped words accepted while full.
REQ-019 Simultaneous push and pop when full SHALL NOT be allowed to push (in_ready decided on registered full flag).
REQ-020 Latency: word pushed at cycle n visible at out_valid no earlier than n+1; order preserved.
REQ-021 out_wren=one-hot of tag when out_valid=1, else all zeros; out_data/out_wren held stable while out_valid&&!out_ready.
REQ-022 Pointers wrap modulo DEPTH; occupancy counter width clog2(DEPTH)+1; empty and full both correct at wrap.
REQ-023 Word index saturates at its maximum; no wrap into low channels.

Reset
REQ-024 rst_n=0 at a clock edge: state S_HDR, buffer emptied, out_valid=0, out_wren=0, out_data=0, in_ready=0, drop_pulse=0.
REQ-025 in_ready SHALL rise the first cycle after rst_n deasserts; reset mid-packet discards the packet remainder's buffered part; subsequent words parsed as from S_HDR.

Configuration
REQ-026 Macro USB_ROUTER_STATS_EN defined: adds outputs pkt_cnt[15:0] (packets entering S_PAY) and drop_cnt[15:0] (drop_pulse count), both wrapping, reset 0.
REQ-027 Macro undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-028 Package usb_router_pkg SHALL hold HDR_MASK, HDR_MATCH, mode constants MODE_SEG=8'h00, MODE_ONE=8'h01, parser state encoding.
REQ-029 Buffer SHALL be sub-module pkt_fifo (synchronous, single clock, width DATA_W+clog2(NUM_CH), depth DEPTH, registered output).

Verification
REQ-030 Header 32'hFF0001AA? no: send 32'hFF0000AA (mode0, base0), 64 words, SEG_LEN=32 -> words 0-31 with out_wren=bit0, 32-63 with bit1.
REQ-031 Header 32'hFF0105AA (mode1, base5), 10 words -> all 10 with out_wren=bit5, then out_valid=0.
REQ-032 Header base 8'd30 (NUM_CH=24), 5 words -> one drop_pulse, no output, next valid header routed normally.
REQ-033 Mode0 base 23, 40 words -> 32 words on bit23, 8 drop_pulses, no other channel asserted.
REQ-034 out_ready=0, push DEPTH+4 payload words -> in_ready low after DEPTH pushes; release -> all DEPTH+4 words out in order.
REQ-035 Assert rst_n=0 for one cycle mid-packet with 10 words buffered -> out_valid=0 next cycle; next header packet routed correctly.

Source files
------------

// File: rtl/usb_router_pkg.sv
// Shared constants and types for the USB packet router: header match pattern,
// routing modes and parser state encoding.
package usb_router_pkg;

    localparam logic [31:0] HDR_MASK  = 32'hFF0000FF;
    localparam logic [31:0] HDR_MATCH = 32'hFF0000AA;

    localparam logic [7:0] MODE_SEG = 8'h00;
    localparam logic [7:0] MODE_ONE = 8'h01;

    // Width of the per-packet payload word index (saturating)
    localparam int unsigned IDX_W = 16;

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_PAY  = 2'd1,
        S_DROP = 2'd2
    } parse_state_e;

    function automatic logic is_header(input logic [31:0] word);
        return (word & HDR_MASK) == HDR_MATCH;
    endfunction

endpackage

// File: rtl/usb_pkt_router_if.sv
// Stream bundle for the USB packet router: USB word input, channel-tagged
// output with one-hot DAC write enables, and the drop indication.
interface usb_pkt_router_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_CH = 24
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_last;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [NUM_CH-1:0] out_wren;
    logic              drop_pulse;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_wren, drop_pulse
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_wren, drop_pulse
    );

endinterface

// File: rtl/pkt_fifo.sv
// Single-clock FIFO with a registered output stage; occupancy includes the
// output register so full_o reflects everything held by the block.
module pkt_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 256
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d, mem_cnt;
    logic             full_q, full_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             push_ok, pop, load;

    always_comb begin
        push_ok     = push_i && !full_q;
        pop         = out_valid_q && pop_i;
        mem_cnt     = cnt_q - CW'(out_valid_q);
        // Refill the output stage whenever it is empty or being consumed
        load        = (mem_cnt != '0) && (!out_valid_q || pop_i);
        wr_ptr_d    = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d    = load ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d       = cnt_q + CW'(push_ok) - CW'(pop);
        full_d      = (cnt_d == CW'(DEPTH));
        out_valid_d = load || (out_valid_q && !pop);
        out_data_d  = load ? mem_q[rd_ptr_q] : out_data_q;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign full_o      = full_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

endmodule

// File: rtl/usb_pkt_router.sv
// USB packet router: parses headers, tags payload words with a DAC channel and
// buffers them. Define USB_ROUTER_STATS_EN to add pkt_cnt/drop_cnt outputs.
module usb_pkt_router
    import usb_router_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned NUM_CH  = 24,
    parameter int unsigned SEG_LEN = 32
) (
    input  logic              clock,
    input  logic              rst_n,
    usb_pkt_router_if.slave   bus
`ifdef USB_ROUTER_STATS_EN
    ,
    output logic [15:0]       pkt_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam int unsigned TAG_W = $clog2(NUM_CH);
    localparam int unsigned FW    = DATA_W + TAG_W;

    parse_state_e     state_q, state_d;
    logic [7:0]       mode_q, mode_d, base_q, base_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rdy_en_q;

    logic [7:0]        hdr_mode, hdr_base;
    logic              hdr_fields_ok, hdr_ok;
    logic [31:0]       seg_ch, chan;
    logic              chan_ok, would_push, in_ready, accept, push, drop;
    logic              fifo_full, fifo_valid;
    logic [FW-1:0]     fifo_out;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_word;
    logic [NUM_CH-1:0] out_wren;

    always_comb begin
        hdr_mode      = bus.in_data[23:16];
        hdr_base      = bus.in_data[15:8];
        hdr_fields_ok = is_header(bus.in_data[31:0]) && (32'(hdr_base) < NUM_CH) &&
                        (hdr_mode == MODE_SEG || hdr_mode == MODE_ONE);
        hdr_ok        = hdr_fields_ok && !bus.in_last;
        seg_ch        = 32'(base_q) + 32'(idx_q) / SEG_LEN;
        chan          = (mode_q == MODE_SEG) ? seg_ch : 32'(base_q);
        chan_ok       = chan < NUM_CH;
        would_push    = (state_q == S_PAY) && chan_ok;
        // Only words headed for the buffer are back-pressured
        in_ready      = rdy_en_q && !(would_push && fifo_full);
        accept        = bus.in_valid && in_ready;
        push          = accept && would_push;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        base_d  = base_q;
        idx_d   = idx_q;
        drop    = 1'b0;
        case (state_q)
            S_HDR: begin
                if (accept) begin
                    if (hdr_ok) begin
                        mode_d  = hdr_mode;
                        base_d  = hdr_base;
                        idx_d   = '0;
                        state_d = S_PAY;
                    end else if (!hdr_fields_ok) begin
                        drop = 1'b1;
                        if (!bus.in_last) state_d = S_DROP;
                    end
                end
            end
            S_PAY: begin
                if (accept) begin
                    drop = !chan_ok;
                    if (idx_q != '1) idx_d = idx_q + IDX_W'(1);
                    if (bus.in_last) state_d = S_HDR;
                end
            end
            S_DROP: begin
                if (accept && bus.in_last) state_d = S_HDR;
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q  <= S_HDR;
            mode_q   <= MODE_SEG;
            base_q   <= '0;
            idx_q    <= '0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            base_q   <= base_d;
            idx_q    <= idx_d;
            rdy_en_q <= 1'b1;
        end
    end

    pkt_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i ({chan[TAG_W-1:0], bus.in_data}),
        .full_o      (fifo_full),
        .pop_i       (bus.out_ready),
        .out_valid_o (fifo_valid),
        .out_data_o  (fifo_out)
    );

    assign {out_tag, out_word} = fifo_out;

    always_comb begin
        out_wren = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            out_wren[i] = fifo_valid && (out_tag == TAG_W'(i));
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_data   = out_word;
    assign bus.out_valid  = fifo_valid;
    assign bus.out_wren   = out_wren;
    assign bus.drop_pulse = drop;

`ifdef USB_ROUTER_STATS_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;

    always_comb begin
        pkt_cnt_d  = pkt_cnt_q + 16'(accept && (state_q == S_HDR) && hdr_ok);
        drop_cnt_d = drop_cnt_q + 16'(drop);
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_usb_pkt_router.sv
// Self-checking bench for usb_pkt_router: directed packets plus random traffic
// scored against a packet-level reference model.
module tb_usb_pkt_router;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned DEPTH   = 256;
    localparam int unsigned NUM_CH  = 24;
    localparam int unsigned SEG_LEN = 32;

    typedef struct {
        logic [31:0] d;
        int unsigned ch;
    } exp_t;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    usb_pkt_router_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus ();

`ifdef USB_ROUTER_STATS_EN
    logic [15:0] pkt_cnt, drop_cnt;
`endif

    usb_pkt_router #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .NUM_CH  (NUM_CH),
        .SEG_LEN (SEG_LEN)
    ) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef USB_ROUTER_STATS_EN
        ,
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    exp_t exp_q[$];
    int   n_tests = 0, n_fail = 0;
    int   drop_seen = 0, drop_exp = 0, pkt_exp = 0, pkt_base = 0, drop_base = 0;
    int   ready_mode = 1;
    bit   gaps = 1'b0;
    bit   mon_en = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (bus.drop_pulse) drop_seen++;
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        check_eq("spurious_out", 64'(bus.out_valid), 64'd0);
                    end else begin
                        check_eq("out_data", 64'(bus.out_data), 64'(exp_q[0].d));
                        check_eq("out_wren", 64'(bus.out_wren), 64'd1 << exp_q[0].ch);
                        if (bus.out_ready) void'(exp_q.pop_front());
                    end
                end else begin
                    check_eq("wren_idle", 64'(bus.out_wren), 64'd0);
                end
            end
        end
    endtask

    task automatic ready_driver();
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom % 4) != 0;
            endcase
        end
    endtask

    // Entered and left at posedge+1
    task automatic send_word(input logic [31:0] d, input logic last);
        int n = 0;
        if (gaps && ($urandom % 4) == 0) begin
            bus.in_valid = 1'b0;
            repeat (1 + $urandom % 2) @(posedge clock);
            #1;
        end
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        @(negedge clock);
        while (!bus.in_ready && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (!bus.in_ready) check_eq("in_ready_stuck", 64'(bus.in_ready), 64'd1);
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_nonhdr();
        logic [31:0] w = $urandom;
        while ((w & 32'hFF0000FF) == 32'hFF0000AA) w = $urandom;
        return w;
    endfunction

    // Reference model: decide the fate of every word from the header rules
    task automatic send_packet(input logic [31:0] hdr, input int len);
        logic [7:0]  mode = hdr[23:16];
        logic [7:0]  base = hdr[15:8];
        bit          good;
        int unsigned ch;
        logic [31:0] d;
        good = ((hdr & 32'hFF0000FF) == 32'hFF0000AA) && (base < NUM_CH) && (mode <= 8'd1)
               && (len > 0);
        if (good) pkt_exp++;
        else drop_exp++;
        send_word(hdr, len == 0);
        for (int k = 0; k < len; k++) begin
            d = $urandom;
            if (good) begin
                ch = (mode == 8'd0) ? int'(base) + k / SEG_LEN : int'(base);
                if (ch < NUM_CH) exp_q.push_back('{d: d, ch: ch});
                else drop_exp++;
            end
            send_word(d, k == len - 1);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        ready_mode = 1;
        while (exp_q.size() != 0 && n < 5000) begin
            @(posedge clock);
            n++;
        end
        repeat (4) @(posedge clock);
        #1;
        check_eq({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        check_eq({tag, "_drops"}, 64'(drop_seen), 64'(drop_exp));
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  m, b;
        int          kind, len;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        fork
            monitor();
            ready_driver();
        join_none

        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_wren", 64'(bus.out_wren), 64'd0);
        check_eq("rst_out_data", 64'(bus.out_data), 64'd0);
        check_eq("rst_drop", 64'(bus.drop_pulse), 64'd0);
        rst_n = 1'b1;
        @(posedge clock);
        #1;
        check_eq("ready_after_rst", 64'(bus.in_ready), 64'd1);
        mon_en = 1'b1;

        send_packet(32'hFF0000AA, 64);
        drain("seg_base0");
        send_packet(32'hFF0105AA, 10);
        drain("single_base5");
        send_packet(32'hFF001EAA, 5);
        send_packet(32'hFF0102AA, 6);
        drain("bad_base");
        send_packet(32'hFF0017AA, 40);
        drain("seg_overflow");

        // Back-pressure: buffer fills after DEPTH words with the output stalled
        ready_mode = 0;
        pkt_exp++;
        send_word(32'hFF0103AA, 1'b0);
        for (int i = 0; i < int'(DEPTH); i++) begin
            d = $urandom;
            exp_q.push_back('{d: d, ch: 3});
            send_word(d, 1'b0);
        end
        d = $urandom;
        exp_q.push_back('{d: d, ch: 3});
        bus.in_data  = d;
        bus.in_last  = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clock);
        check_eq("full_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (3) @(negedge clock);
        check_eq("full_in_ready_hold", 64'(bus.in_ready), 64'd0);
        @(posedge clock);
        #1;
        ready_mode = 1;
        send_word(d, 1'b0);
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            exp_q.push_back('{d: d, ch: 3});
            send_word(d, i == 2);
        end
        drain("backpressure");

        // Reset in the middle of a packet with ten words buffered
        ready_mode = 0;
        pkt_exp++;
        send_word(32'hFF0004AA, 1'b0);
        for (int i = 0; i < 10; i++) begin
            d = $urandom;
            exp_q.push_back('{d: d, ch: 4});
            send_word(d, 1'b0);
        end
        rst_n = 1'b0;
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        pkt_base  = pkt_exp;
        drop_base = drop_exp;
        check_eq("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clock);
        #1;
        check_eq("midrst_ready_back", 64'(bus.in_ready), 64'd1);
        send_packet(rand_nonhdr(), 2);
        ready_mode = 1;
        send_packet(32'hFF0006AA, 12);
        drain("after_reset");

        gaps       = 1'b1;
        ready_mode = 2;
        for (int p = 0; p < 40; p++) begin
            kind = $urandom % 6;
            len  = 1 + $urandom % 80;
            m    = 8'($urandom % 2);
            b    = 8'($urandom % NUM_CH);
            case (kind)
                0:       send_packet({8'hFF, 8'h00, b, 8'hAA}, len);
                1:       send_packet({8'hFF, 8'h01, b, 8'hAA}, len);
                2:       send_packet({8'hFF, 8'h00, 8'(16 + $urandom % 8), 8'hAA}, len);
                3:       send_packet({8'hFF, m, 8'(24 + $urandom % 232), 8'hAA}, len);
                4:       send_packet({8'hFF, 8'(2 + $urandom % 254), b, 8'hAA}, len);
                default: send_packet(rand_nonhdr(), $urandom % 5);
            endcase
            ready_mode = 2;
        end
        gaps = 1'b0;
        drain("random");

`ifdef USB_ROUTER_STATS_EN
        check_eq("pkt_cnt", 64'(pkt_cnt), 64'(16'(pkt_exp - pkt_base)));
        check_eq("drop_cnt", 64'(drop_cnt), 64'(16'(drop_exp - drop_base)));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
